// File: rtl/turno_memoria_ctrl.sv
// rtl/turno_memoria_ctrl.sv - turn sequencer for the 16-card two-player memory game
module turno_memoria_ctrl #(
    parameter int TURN_TICKS = 15,
    parameter int SHOW_TICKS = 2,
    parameter int NPAIRS     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_game,
    input  logic [15:0][4:0] deck_in,
    input  logic             sel_valid,
    input  logic [3:0]       sel_pos,
    input  logic             tick_1hz,
    output logic             ver_start,
    output logic [15:0][4:0] ver_cards_out,
    input  logic [15:0][4:0] ver_cards_in,
    input  logic             ver_done,
    input  logic             ver_pair,
    output logic [15:0][4:0] board,
    output logic             player,
    output logic [3:0]       score0,
    output logic [3:0]       score1,
    output logic [4:0]       time_left,
    output logic             game_over,
    output logic [1:0]       winner
);

    localparam logic [4:0] TURN_RELOAD = 5'(TURN_TICKS);
    localparam logic [2:0] SHOW_RELOAD = 3'(SHOW_TICKS);
    localparam logic [3:0] PAIRS_ALL   = 4'(NPAIRS);

    localparam logic [1:0] CARD_CLOSED  = 2'b00;
    localparam logic [1:0] CARD_OPEN    = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        PICK1,
        PICK2,
        SHOW,
        VSTART,
        VWAIT,
        OVER
    } state_t;

    state_t           state, state_n;
    logic [15:0][4:0] board_n;
    logic             player_n;
    logic [3:0]       score0_n, score1_n;
    logic [3:0]       pairs, pairs_n;
    logic [4:0]       time_left_n;
    logic             game_over_n;
    logic [1:0]       winner_n;
    logic             ver_start_n;
    logic [3:0]       pos1, pos1_n;
    logic [2:0]       show_cnt, show_cnt_n;

    logic             timer_tick;
    logic             expire;
    logic             sel_closed;
    logic             unused_deck_bits;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // The verifier always sees the live board; it only changes again once ver_done lands.
    assign ver_cards_out = board;

    // Only the symbol field of the deck is loaded; fold the status bits away.
    always_comb begin
        unused_deck_bits = 1'b0;
        for (int i = 0; i < 16; i++) begin
            unused_deck_bits = unused_deck_bits ^ (^deck_in[i][1:0]);
        end
    end

    // Next-state and next-output logic; new_game is applied last so it overrides every state.
    always_comb begin
        state_n     = state;
        board_n     = board;
        player_n    = player;
        score0_n    = score0;
        score1_n    = score1;
        pairs_n     = pairs;
        time_left_n = time_left;
        game_over_n = game_over;
        winner_n    = winner;
        ver_start_n = 1'b0;
        pos1_n      = pos1;
        show_cnt_n  = show_cnt;

        timer_tick = tick_1hz && (state == PICK1 || state == PICK2);
        expire     = timer_tick && (time_left == 5'd1);
        sel_closed = (board[sel_pos][1:0] == CARD_CLOSED);

        case (state)
            PICK1, PICK2: begin
                if (expire) begin
                    if (board[pos1][1:0] == CARD_OPEN) begin
                        board_n[pos1][1:0] = CARD_CLOSED;
                    end
                    player_n    = ~player;
                    time_left_n = TURN_RELOAD;
                    state_n     = PICK1;
                end else begin
                    if (timer_tick && time_left != 5'd0) begin
                        time_left_n = time_left - 5'd1;
                    end
                    if (state == PICK1 && sel_valid && sel_closed) begin
                        board_n[sel_pos][1:0] = CARD_OPEN;
                        pos1_n                = sel_pos;
                        state_n               = PICK2;
                    end else if (state == PICK2 && sel_valid && sel_closed && sel_pos != pos1) begin
                        board_n[sel_pos][1:0] = CARD_OPEN;
                        show_cnt_n            = SHOW_RELOAD;
                        state_n               = SHOW;
                    end
                end
            end
            SHOW: begin
                if (tick_1hz) begin
                    if (show_cnt <= 3'd1) begin
                        ver_start_n = 1'b1;
                        state_n     = VSTART;
                    end else begin
                        show_cnt_n = show_cnt - 3'd1;
                    end
                end
            end
            VSTART: begin
                state_n = VWAIT;
            end
            VWAIT: begin
                if (ver_done) begin
                    board_n = ver_cards_in;
                    if (ver_pair) begin
                        if (player) begin
                            score1_n = sat_inc(score1);
                        end else begin
                            score0_n = sat_inc(score0);
                        end
                        pairs_n = sat_inc(pairs);
                        if (pairs_n == PAIRS_ALL) begin
                            game_over_n = 1'b1;
                            if (score0_n > score1_n) begin
                                winner_n = 2'b01;
                            end else if (score1_n > score0_n) begin
                                winner_n = 2'b10;
                            end else begin
                                winner_n = 2'b11;
                            end
                            state_n = OVER;
                        end else begin
                            time_left_n = TURN_RELOAD;
                            state_n     = PICK1;
                        end
                    end else begin
                        player_n    = ~player;
                        time_left_n = TURN_RELOAD;
                        state_n     = PICK1;
                    end
                end
            end
            default: begin
                state_n = state;
            end
        endcase

        if (new_game) begin
            for (int i = 0; i < 16; i++) begin
                board_n[i] = {deck_in[i][4:2], CARD_CLOSED};
            end
            player_n    = 1'b0;
            score0_n    = 4'd0;
            score1_n    = 4'd0;
            pairs_n     = 4'd0;
            time_left_n = TURN_RELOAD;
            game_over_n = 1'b0;
            winner_n    = 2'b00;
            ver_start_n = 1'b0;
            state_n     = PICK1;
        end
    end

    // State and registered outputs; reset blanks the board and drops any pending handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            for (int i = 0; i < 16; i++) begin
                board[i] <= 5'b00011;
            end
            player    <= 1'b0;
            score0    <= 4'd0;
            score1    <= 4'd0;
            pairs     <= 4'd0;
            time_left <= 5'd0;
            game_over <= 1'b0;
            winner    <= 2'b00;
            ver_start <= 1'b0;
            pos1      <= 4'd0;
            show_cnt  <= 3'd0;
        end else begin
            state     <= state_n;
            board     <= board_n;
            player    <= player_n;
            score0    <= score0_n;
            score1    <= score1_n;
            pairs     <= pairs_n;
            time_left <= time_left_n;
            game_over <= game_over_n;
            winner    <= winner_n;
            ver_start <= ver_start_n;
            pos1      <= pos1_n;
            show_cnt  <= show_cnt_n;
        end
    end

endmodule

// File: tb/tb_turno_memoria_ctrl.sv
// tb/tb_turno_memoria_ctrl.sv - scoreboard bench for turno_memoria_ctrl
module tb_turno_memoria_ctrl;

    localparam int TURN = 15;
    localparam int SHOWT = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             new_game = 1'b0;
    logic [15:0][4:0] deck_in = '0;
    logic             sel_valid = 1'b0;
    logic [3:0]       sel_pos = 4'd0;
    logic             tick_1hz = 1'b0;
    logic             ver_start;
    logic [15:0][4:0] ver_cards_out;
    logic [15:0][4:0] ver_cards_in = '0;
    logic             ver_done = 1'b0;
    logic             ver_pair = 1'b0;
    logic [15:0][4:0] board;
    logic             player;
    logic [3:0]       score0, score1;
    logic [4:0]       time_left;
    logic             game_over;
    logic [1:0]       winner;

    turno_memoria_ctrl #(.TURN_TICKS(TURN), .SHOW_TICKS(SHOWT), .NPAIRS(8)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .deck_in(deck_in),
        .sel_valid(sel_valid), .sel_pos(sel_pos), .tick_1hz(tick_1hz),
        .ver_start(ver_start), .ver_cards_out(ver_cards_out),
        .ver_cards_in(ver_cards_in), .ver_done(ver_done), .ver_pair(ver_pair),
        .board(board), .player(player), .score0(score0), .score1(score1),
        .time_left(time_left), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [15:0][4:0] m_board;
    logic             m_player;
    logic [3:0]       m_s0, m_s1, m_pairs;
    logic [4:0]       m_time;
    logic             m_go;
    logic [1:0]       m_win;

    typedef struct packed {
        logic [79:0] brd;
        logic        pl;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [4:0]  tl;
        logic        go;
        logic [1:0]  win;
    } snap_t;

    snap_t       sq[$];
    string       sn[$];
    logic [79:0] vq[$];
    logic        snap_req = 1'b0;
    snap_t       mon_e;
    string       mon_n;
    logic [79:0] mon_v;

    logic [15:0][4:0] deck1, deck2;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations when the DUT strobes ver_start or a snapshot is requested.
    always @(negedge clk) begin
        if (ver_start === 1'b1) begin
            if (vq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ver_start_unexpected: got 1 expected 0");
            end else begin
                mon_v = vq.pop_front();
                chk("ver_cards_out", ver_cards_out, mon_v);
            end
        end
        if (snap_req) begin
            if (sq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL snap_queue: got empty expected entry");
            end else begin
                mon_e = sq.pop_front();
                mon_n = sn.pop_front();
                chk({mon_n, ".board"},     board,     mon_e.brd);
                chk({mon_n, ".player"},    player,    mon_e.pl);
                chk({mon_n, ".score0"},    score0,    mon_e.s0);
                chk({mon_n, ".score1"},    score1,    mon_e.s1);
                chk({mon_n, ".time_left"}, time_left, mon_e.tl);
                chk({mon_n, ".game_over"}, game_over, mon_e.go);
                chk({mon_n, ".winner"},    winner,    mon_e.win);
                chk({mon_n, ".ver_start"}, ver_start, 1'b0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input string nm);
        snap_t s;
        s.brd = m_board;
        s.pl  = m_player;
        s.s0  = m_s0;
        s.s1  = m_s1;
        s.tl  = m_time;
        s.go  = m_go;
        s.win = m_win;
        sq.push_back(s);
        sn.push_back(nm);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
    endtask

    task automatic sel(input logic [3:0] p);
        sel_valid = 1'b1;
        sel_pos   = p;
        step();
        sel_valid = 1'b0;
    endtask

    task automatic tk();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_board[i] = 5'b00011;
        m_player = 1'b0;
        m_s0 = 4'd0;
        m_s1 = 4'd0;
        m_pairs = 4'd0;
        m_time = 5'd0;
        m_go = 1'b0;
        m_win = 2'b00;
    endtask

    task automatic start_game(input logic [15:0][4:0] d);
        deck_in  = d;
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        for (int i = 0; i < 16; i++) m_board[i] = {d[i][4:2], 2'b00};
        m_player = 1'b0;
        m_s0 = 4'd0;
        m_s1 = 4'd0;
        m_pairs = 4'd0;
        m_time = 5'(TURN);
        m_go = 1'b0;
        m_win = 2'b00;
    endtask

    task automatic wait_ver(input string nm);
        int n;
        n = 0;
        while (ver_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (ver_start !== 1'b1) begin
            bad++;
            $display("FAIL %s.ver_start_wait: got timeout expected pulse", nm);
        end
    endtask

    task automatic turn(input logic [3:0] a, input logic [3:0] b, input string nm);
        logic [15:0][4:0] res;
        logic             pair;
        sel(a);
        m_board[a][1:0] = 2'b01;
        sel(b);
        m_board[b][1:0] = 2'b01;
        repeat (SHOWT - 1) tk();
        snap({nm, ".show_hold"});
        vq.push_back(m_board);
        tk();
        wait_ver(nm);
        step();
        res  = m_board;
        pair = (m_board[a][4:2] == m_board[b][4:2]);
        res[a][1:0] = pair ? 2'b10 : 2'b00;
        res[b][1:0] = pair ? 2'b10 : 2'b00;
        ver_cards_in = res;
        ver_pair     = pair;
        ver_done     = 1'b1;
        step();
        ver_done = 1'b0;
        ver_pair = 1'b0;
        m_board = res;
        if (pair) begin
            if (m_player) m_s1 = m_s1 + 4'd1;
            else          m_s0 = m_s0 + 4'd1;
            m_pairs = m_pairs + 4'd1;
            if (m_pairs == 4'd8) begin
                m_go  = 1'b1;
                m_win = (m_s0 > m_s1) ? 2'b01 : (m_s1 > m_s0) ? 2'b10 : 2'b11;
            end else begin
                m_time = 5'(TURN);
            end
        end else begin
            m_player = ~m_player;
            m_time   = 5'(TURN);
        end
        snap({nm, ".result"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            deck1[i] = {3'(i >> 1), 2'b11};
            deck2[i] = {3'((15 - i) >> 1), 2'b01};
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        snap("reset");

        // 1: load deck, symbols i>>1
        start_game(deck1);
        snap("new_game");

        // 2: matching pair by player 0
        turn(4'd0, 4'd1, "t2_match");

        // 3: three timer ticks, then mismatch; timer frozen in SHOW, reload after
        repeat (3) tk();
        m_time = m_time - 5'd3;
        turn(4'd2, 4'd4, "t3_miss");

        // 4: re-select and matched select ignored, then timeout in PICK2
        sel(4'd5);
        m_board[5][1:0] = 2'b01;
        sel(4'd5);
        sel(4'd0);
        snap("t4_ignored");
        repeat (TURN - 1) tk();
        m_time = 5'd1;
        snap("t4_time_one");
        tk();
        m_board[5][1:0] = 2'b00;
        m_player = ~m_player;
        m_time = 5'(TURN);
        snap("t4_timeout");

        // 5: expiry and select in the same cycle
        repeat (TURN - 1) tk();
        sel_valid = 1'b1;
        sel_pos   = 4'd3;
        tick_1hz  = 1'b1;
        step();
        sel_valid = 1'b0;
        tick_1hz  = 1'b0;
        m_player = ~m_player;
        m_time = 5'(TURN);
        snap("t5_expire_beats_sel");

        // 6: finish the game, score0=5 score1=3
        turn(4'd2, 4'd3, "t6_p1_a");
        turn(4'd4, 4'd5, "t6_p1_b");
        turn(4'd6, 4'd7, "t6_p1_c");
        turn(4'd8, 4'd10, "t6_p1_miss");
        turn(4'd8, 4'd9, "t6_p0_a");
        turn(4'd10, 4'd11, "t6_p0_b");
        turn(4'd12, 4'd13, "t6_p0_c");
        turn(4'd14, 4'd15, "t6_p0_last");

        // new_game while waiting on the verifier
        start_game(deck2);
        sel(4'd0);
        m_board[0][1:0] = 2'b01;
        sel(4'd1);
        m_board[1][1:0] = 2'b01;
        tk();
        vq.push_back(m_board);
        tk();
        wait_ver("vwait_restart");
        step();
        start_game(deck1);
        snap("new_game_mid_vwait");

        // a stale ver_done outside VWAIT must not touch the board
        for (int i = 0; i < 16; i++) ver_cards_in[i] = 5'b11110;
        ver_done = 1'b1;
        ver_pair = 1'b1;
        step();
        ver_done = 1'b0;
        ver_pair = 1'b0;
        snap("late_done_ignored");

        // reset while showing two cards
        sel(4'd0);
        sel(4'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        snap("reset_mid_show");
        repeat (4) tk();
        sel(4'd3);
        snap("idle_after_reset");

        repeat (3) step();
        total++;
        if (sq.size() != 0 || vq.size() != 0) begin
            bad++;
            $display("FAIL queues_drained: got %0d/%0d expected 0/0", sq.size(), vq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
